board_cursor_ctl: RTL and testbench
===================================

Name: board_cursor_ctl

Overview:
- Parametrised successor of the mouse-to-board pick/place controller between MouseCtl position/button outputs and chess_board.
- Maps mouse coordinates to a square index on a configurable FILES x RANKS board, debounces both buttons, and runs a pick/place/cancel state machine.
- Supports click-click and press-drag-release modes; adds right-button cancel and hover reporting.

Parameters:
FILES, 8, board columns (1..16)
RANKS, 8, board rows (1..16)
SQ_SIZE, 96, square edge in pixels
X0, 128, board left edge pixel
Y0, 0, board top edge pixel
COORD_W, 12, mouse coordinate width
DEBOUNCE, 4, consecutive stable cycles to accept a button change (>=1)
DRAG_MODE, 0, 0 = click-to-pick/click-to-place, 1 = press-to-pick/release-to-place
(localparam IDX_W = $clog2(FILES*RANKS), minimum 1)

Ports:
clk  in  1  system clock (65 MHz domain); one clock only
rst  in  1  synchronous, active-high reset
xpos  in  COORD_W  mouse x, already in clk domain
ypos  in  COORD_W  mouse y, already in clk domain
lmb  in  1  raw left button
rmb  in  1  raw right button
pick_allowed  in  1  hovered square holds a piece the side to move may lift; sampled with press edge
hover_valid  out  1  pointer inside board
hover_idx  out  IDX_W  rank*FILES+file, rank 0 = top row, file 0 = left
held  out  1  piece currently lifted
src_idx  out  IDX_W  square of lifted piece
dst_idx  out  IDX_W  target square of last placement
pick_piece  out  1  one-cycle pulse
place_piece  out  1  one-cycle pulse
cancel  out  1  one-cycle pulse, piece returned to src

Behaviour:
- Reset: all outputs 0, FSM IDLE, filters and counters 0. Reset in HELD returns to IDLE with no cancel pulse.
- Mapping, 2-stage registered pipeline, latency 2 cycles from xpos/ypos to hover_*:
  - Stage 1 registers dx = x-X0, dy = y-Y0 and the in-range flags X0 <= x < X0+FILES*SQ_SIZE and Y0 <= y < Y0+RANKS*SQ_SIZE. Upper bounds are exclusive.
  - Stage 2: file = count of k in 1..FILES-1 with dx >= k*SQ_SIZE; rank likewise. No divider.
  - hover_valid = both flags. When invalid, hover_idx holds its last value.
- Debounce, same filter per button:
  - Raw input registered once (raw_s). Counter increments each cycle raw_s != filt and clears when equal.
  - When the counter would reach DEBOUNCE, filt <= raw_s and the counter clears. filt therefore flips DEBOUNCE cycles after raw_s first differs.
  - Edge = filt & ~filt_d, registered into the FSM. A pulse output asserts DEBOUNCE+2 cycles after the first clk edge sampling the new raw level.
- FSM states IDLE, HELD. held = (state==HELD).
- IDLE transitions:
  - L-press edge with hover_valid & pick_allowed: pick_piece pulse, src_idx <= hover_idx, go to HELD.
  - Otherwise (press off-board, not allowed, rmb activity): ignored.
- HELD, "commit event" = L-press edge (DRAG_MODE=0) or L-release edge (DRAG_MODE=1). In DRAG_MODE=1, press edges in HELD are ignored.
  - R-press edge: cancel, go to IDLE. This takes priority over a simultaneous commit event.
  - Commit with hover_valid and hover_idx != src_idx: place_piece, dst_idx <= hover_idx, go to IDLE.
  - Commit with hover_idx == src_idx or off-board: cancel, go to IDLE.
- Pulses are registered and mutually exclusive, at most one per cycle. src_idx and dst_idx hold until overwritten.
- Press and release edges of one button cannot occur in the same cycle. A new press is accepted only after a full filtered release.

Test Plan:
1. Mapping at defaults: (128,0)->0, (223,95)->0, (224,96)->9, (895,767)->63 valid; (127,0), (896,100), (500,768) -> hover_valid=0. hover_* updates exactly 2 cycles after the coordinate change.
2. Click mode: pointer at (300,200) gives idx 17, pick_allowed=1, lmb high 10 cycles -> single pick_piece 6 cycles after the sampling edge, src_idx=17, held=1. Move to (500,500) gives idx 43, click -> place_piece, dst_idx=43, held=0.
3. Debounce: lmb high 3 cycles then low -> no pulse, held=0. lmb high 4 cycles -> pick_piece. pick_allowed=0 at press -> no pulse.
4. Cancel: HELD at 17, click on 17 -> cancel only. HELD, rmb and lmb filtered edges in the same cycle on square 43 -> cancel, no place_piece, dst_idx unchanged.
5. DRAG_MODE=1: press at 17 -> pick_piece. Release at 43 -> place_piece, dst_idx=43. Repeat with release at (100,100) -> cancel.
6. Assert rst for one cycle while HELD -> next cycle all outputs 0, no cancel pulse. A subsequent pick works normally.

Source files
------------

// File: rtl/board_cursor_ctl.sv
// Mouse-to-board cursor controller: maps pointer to a square, debounces both
// buttons and runs the pick/place/cancel state machine.
module board_cursor_ctl #(
    parameter int unsigned FILES     = 8,
    parameter int unsigned RANKS     = 8,
    parameter int unsigned SQ_SIZE   = 96,
    parameter int unsigned X0        = 128,
    parameter int unsigned Y0        = 0,
    parameter int unsigned COORD_W   = 12,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned DRAG_MODE = 0,
    localparam int unsigned IDX_W    = (FILES * RANKS > 1) ? $clog2(FILES * RANKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               lmb,
    input  logic               rmb,
    input  logic               pick_allowed,
    output logic               hover_valid,
    output logic [IDX_W-1:0]   hover_idx,
    output logic               held,
    output logic [IDX_W-1:0]   src_idx,
    output logic [IDX_W-1:0]   dst_idx,
    output logic               pick_piece,
    output logic               place_piece,
    output logic               cancel
);

    localparam int unsigned X_SPAN = FILES * SQ_SIZE;
    localparam int unsigned Y_SPAN = RANKS * SQ_SIZE;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    // Stage 1: offsets from the board origin; bit 32 set means left of / above the board
    logic [32:0]        x_off;
    logic [32:0]        y_off;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic               in_x;
    logic               in_y;

    assign x_off = {1'b0, 32'(xpos)} - {1'b0, 32'(X0)};
    assign y_off = {1'b0, 32'(ypos)} - {1'b0, 32'(Y0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            dx   <= '0;
            dy   <= '0;
            in_x <= 1'b0;
            in_y <= 1'b0;
        end else begin
            dx   <= x_off[COORD_W-1:0];
            dy   <= y_off[COORD_W-1:0];
            in_x <= ~x_off[32] && (x_off[31:0] < X_SPAN);
            in_y <= ~y_off[32] && (y_off[31:0] < Y_SPAN);
        end
    end

    // Stage 2: square coordinate by threshold counting instead of division
    int unsigned file_c;
    int unsigned rank_c;

    always_comb begin
        file_c = 0;
        rank_c = 0;
        for (int unsigned k = 1; k < FILES; k++) begin
            if (32'(dx) >= k * SQ_SIZE) file_c = file_c + 32'd1;
        end
        for (int unsigned k = 1; k < RANKS; k++) begin
            if (32'(dy) >= k * SQ_SIZE) rank_c = rank_c + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hover_valid <= 1'b0;
            hover_idx   <= '0;
        end else begin
            hover_valid <= in_x & in_y;
            if (in_x & in_y) hover_idx <= IDX_W'(rank_c * FILES + file_c);
        end
    end

    // Button filters, bit 0 = left, bit 1 = right
    logic [1:0]       raw_s;
    logic [1:0]       filt;
    logic [1:0]       filt_d;
    logic [1:0]       press_e;
    logic [1:0]       rel_e;
    logic [CNT_W-1:0] db_cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_s     <= '0;
            filt      <= '0;
            filt_d    <= '0;
            press_e   <= '0;
            rel_e     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            raw_s   <= {rmb, lmb};
            filt_d  <= filt;
            press_e <= filt & ~filt_d;
            rel_e   <= ~filt & filt_d;
            for (int b = 0; b < 2; b++) begin
                if (raw_s[b] == filt[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CNT_W'(DEBOUNCE - 1)) begin
                    filt[b]   <= raw_s[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Pick/place state machine
    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] src_next;
    logic [IDX_W-1:0] dst_next;
    logic             pick_c;
    logic             place_c;
    logic             cancel_c;
    logic             commit_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src_idx     <= '0;
            dst_idx     <= '0;
            pick_piece  <= 1'b0;
            place_piece <= 1'b0;
            cancel      <= 1'b0;
        end else begin
            state       <= state_next;
            src_idx     <= src_next;
            dst_idx     <= dst_next;
            pick_piece  <= pick_c;
            place_piece <= place_c;
            cancel      <= cancel_c;
        end
    end

    always_comb begin
        state_next = state;
        src_next   = src_idx;
        dst_next   = dst_idx;
        pick_c     = 1'b0;
        place_c    = 1'b0;
        cancel_c   = 1'b0;
        commit_c   = (DRAG_MODE != 0) ? rel_e[0] : press_e[0];
        case (state)
            IDLE: begin
                if (press_e[0] && hover_valid && pick_allowed) begin
                    pick_c     = 1'b1;
                    src_next   = hover_idx;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (press_e[1]) begin
                    cancel_c   = 1'b1;
                    state_next = IDLE;
                end else if (commit_c) begin
                    if (hover_valid && (hover_idx != src_idx)) begin
                        place_c  = 1'b1;
                        dst_next = hover_idx;
                    end else begin
                        cancel_c = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign held = (state == HELD);

endmodule

// File: tb/tb_board_cursor_ctl.sv
// Bench for board_cursor_ctl: click-mode and drag-mode instances driven with the
// same stimulus and compared every cycle against a behavioural model.
module tb_board_cursor_ctl;

    localparam int FILES = 8;
    localparam int RANKS = 8;
    localparam int SQ    = 96;
    localparam int X0    = 128;
    localparam int Y0    = 0;
    localparam int D     = 4;
    localparam int IDX_W = $clog2(FILES * RANKS);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [11:0]      xpos = '0;
    logic [11:0]      ypos = '0;
    logic             lmb = 1'b0;
    logic             rmb = 1'b0;
    logic             pa = 1'b0;

    logic             hv0, held0, pk0, pl0, cn0;
    logic [IDX_W-1:0] hi0, src0, dst0;
    logic             hv1, held1, pk1, pl1, cn1;
    logic [IDX_W-1:0] hi1, src1, dst1;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    board_cursor_ctl #(.DRAG_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .lmb(lmb), .rmb(rmb),
        .pick_allowed(pa), .hover_valid(hv0), .hover_idx(hi0), .held(held0),
        .src_idx(src0), .dst_idx(dst0), .pick_piece(pk0), .place_piece(pl0), .cancel(cn0)
    );

    board_cursor_ctl #(.DRAG_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .lmb(lmb), .rmb(rmb),
        .pick_allowed(pa), .hover_valid(hv1), .hover_idx(hi1), .held(held1),
        .src_idx(src1), .dst_idx(dst1), .pick_piece(pk1), .place_piece(pl1), .cancel(cn1)
    );

    typedef struct packed {
        logic              in1;
        logic [31:0]       idx1;
        logic              hv;
        logic [31:0]       hidx;
        logic [1:0][D-1:0] hist;
        logic [1:0]        filt;
        logic [1:0]        filtd;
        logic [1:0]        press;
        logic [1:0]        rel;
        logic              held;
        logic [31:0]       src;
        logic [31:0]       dst;
        logic              pick;
        logic              place;
        logic              cncl;
    } mstate_t;

    mstate_t m0 = '0;
    mstate_t m1 = '0;

    // One clock of the reference: square by division, button accepted once the
    // last D registered samples all disagree with the filtered level.
    function automatic mstate_t mstep(input mstate_t m, input bit drag);
        mstate_t n;
        int xi, yi;
        bit diff;
        logic [1:0] raw;
        logic commit;
        if (rst) return '0;
        n = m;
        xi = int'(xpos);
        yi = int'(ypos);
        n.hv = m.in1;
        if (m.in1) n.hidx = m.idx1;
        n.in1 = (xi >= X0) && (xi < X0 + FILES * SQ) && (yi >= Y0) && (yi < Y0 + RANKS * SQ);
        n.idx1 = n.in1 ? 32'(((yi - Y0) / SQ) * FILES + (xi - X0) / SQ) : 32'd0;
        raw = {rmb, lmb};
        for (int b = 0; b < 2; b++) begin
            diff = 1'b1;
            for (int i = 0; i < D; i++) if (m.hist[b][i] == m.filt[b]) diff = 1'b0;
            n.filt[b]  = diff ? ~m.filt[b] : m.filt[b];
            n.hist[b]  = {m.hist[b][D-2:0], raw[b]};
            n.filtd[b] = m.filt[b];
            n.press[b] = m.filt[b] & ~m.filtd[b];
            n.rel[b]   = ~m.filt[b] & m.filtd[b];
        end
        n.pick = 1'b0;
        n.place = 1'b0;
        n.cncl = 1'b0;
        commit = drag ? m.rel[0] : m.press[0];
        if (!m.held) begin
            if (m.press[0] && m.hv && pa) begin
                n.pick = 1'b1;
                n.src = m.hidx;
                n.held = 1'b1;
            end
        end else if (m.press[1]) begin
            n.cncl = 1'b1;
            n.held = 1'b0;
        end else if (commit) begin
            if (m.hv && m.hidx != m.src) begin
                n.place = 1'b1;
                n.dst = m.hidx;
            end else begin
                n.cncl = 1'b1;
            end
            n.held = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = mstep(m0, 1'b0);
        m1 = mstep(m1, 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input mstate_t m, input logic hv, input logic [IDX_W-1:0] hi,
                       input logic hd, input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d,
                       input logic pk, input logic pl, input logic cn);
        chk({t, ".hover_valid"}, 32'(hv), 32'(m.hv));
        chk({t, ".hover_idx"},   32'(hi), m.hidx);
        chk({t, ".held"},        32'(hd), 32'(m.held));
        chk({t, ".src_idx"},     32'(s),  m.src);
        chk({t, ".dst_idx"},     32'(d),  m.dst);
        chk({t, ".pick_piece"},  32'(pk), 32'(m.pick));
        chk({t, ".place_piece"}, 32'(pl), 32'(m.place));
        chk({t, ".cancel"},      32'(cn), 32'(m.cncl));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model0", m0, hv0, hi0, held0, src0, dst0, pk0, pl0, cn0);
            cmp("model1", m1, hv1, hi1, held1, src1, dst1, pk1, pl1, cn1);
        end
    end

    int n_pk[2], n_pl[2], n_cn[2];
    int first_pk0, cyc;

    task automatic clr();
        n_pk = '{0, 0};
        n_pl = '{0, 0};
        n_cn = '{0, 0};
        first_pk0 = 0;
        cyc = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (pk0) begin
                n_pk[0]++;
                if (first_pk0 == 0) first_pk0 = cyc;
            end
            if (pl0) n_pl[0]++;
            if (cn0) n_cn[0]++;
            if (pk1) n_pk[1]++;
            if (pl1) n_pl[1]++;
            if (cn1) n_cn[1]++;
        end
    endtask

    task automatic set_xy(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
    endtask

    task automatic btn(input bit l, input bit r, input int hi, input int lo);
        lmb = l;
        rmb = r;
        run(hi);
        lmb = 1'b0;
        rmb = 1'b0;
        run(lo);
    endtask

    int px[7] = '{128, 223, 224, 895, 127, 896, 500};
    int py[7] = '{0, 95, 96, 767, 0, 100, 768};
    int ev[7] = '{1, 1, 1, 1, 0, 0, 0};
    int ei[7] = '{0, 0, 9, 63, 63, 63, 63};

    initial begin
        int pv, pi;
        clr();
        repeat (3) @(negedge clk);
        chk("rst.hover_valid", 32'(hv0), 0);
        chk("rst.hover_idx", 32'(hi0), 0);
        chk("rst.held", 32'(held0), 0);
        chk("rst.src_idx", 32'(src0), 0);
        chk("rst.dst_idx", 32'(dst0), 0);
        chk("rst.pulses", 32'({pk0, pl0, cn0, pk1, pl1, cn1}), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        run(2);

        // Coordinate mapping and its two-cycle latency
        pv = 0;
        pi = 0;
        for (int i = 0; i < 7; i++) begin
            set_xy(px[i], py[i]);
            @(negedge clk);
            chk("map.lat_valid", 32'(hv0), 32'(pv));
            chk("map.lat_idx", 32'(hi0), 32'(pi));
            @(negedge clk);
            chk("map.valid", 32'(hv0), 32'(ev[i]));
            chk("map.idx", 32'(hi0), 32'(ei[i]));
            pv = ev[i];
            pi = ei[i];
        end

        // Click pick at square 17
        pa = 1'b1;
        set_xy(300, 200);
        run(4);
        clr();
        btn(1, 0, 10, 12);
        chk("click.pick_cnt", 32'(n_pk[0]), 1);
        chk("click.pick_cycle", 32'(first_pk0), 7);
        chk("click.held", 32'(held0), 1);
        chk("click.src", 32'(src0), 17);
        chk("drag.same_sq_cancel", 32'(n_cn[1]), 1);

        // Click place at square 43
        set_xy(500, 500);
        run(4);
        clr();
        btn(1, 0, 10, 12);
        chk("click.place_cnt", 32'(n_pl[0]), 1);
        chk("click.dst", 32'(dst0), 43);
        chk("click.held_after", 32'(held0), 0);

        // Debounce threshold
        set_xy(300, 200);
        run(4);
        clr();
        btn(1, 0, 3, 12);
        chk("deb.short_pick", 32'(n_pk[0] + n_pk[1]), 0);
        chk("deb.short_held", 32'(held0), 0);
        clr();
        btn(1, 0, 4, 12);
        chk("deb.exact_pick", 32'(n_pk[0]), 1);
        chk("deb.exact_src", 32'(src0), 17);

        // Click on source square cancels
        clr();
        btn(1, 0, 10, 12);
        chk("cancel.same_cnt", 32'(n_cn[0]), 1);
        chk("cancel.same_place", 32'(n_pl[0]), 0);
        chk("cancel.same_held", 32'(held0), 0);

        // Not allowed to pick
        pa = 1'b0;
        clr();
        btn(1, 0, 10, 12);
        chk("deny.pick", 32'(n_pk[0] + n_pk[1]), 0);
        pa = 1'b1;

        // Right and left filtered together while held: cancel wins
        clr();
        btn(1, 0, 10, 12);
        set_xy(500, 500);
        run(4);
        clr();
        btn(1, 1, 10, 12);
        chk("cancel.both_cnt", 32'(n_cn[0]), 1);
        chk("cancel.both_place", 32'(n_pl[0]), 0);
        chk("cancel.both_dst", 32'(dst0), 43);

        // Drag mode: press at 17, release at 43
        set_xy(300, 200);
        run(4);
        clr();
        lmb = 1'b1;
        run(10);
        chk("drag.pick_cnt", 32'(n_pk[1]), 1);
        chk("drag.src", 32'(src1), 17);
        set_xy(500, 500);
        run(4);
        clr();
        lmb = 1'b0;
        run(12);
        chk("drag.place_cnt", 32'(n_pl[1]), 1);
        chk("drag.dst", 32'(dst1), 43);
        chk("drag.held", 32'(held1), 0);

        // Drag mode: release off-board cancels
        set_xy(300, 200);
        run(4);
        clr();
        lmb = 1'b1;
        run(10);
        set_xy(100, 100);
        run(4);
        clr();
        lmb = 1'b0;
        run(12);
        chk("drag.off_cancel", 32'(n_cn[1]), 1);
        chk("drag.off_place", 32'(n_pl[1]), 0);

        // Reset while held
        set_xy(300, 200);
        run(4);
        clr();
        btn(1, 0, 10, 12);
        chk("rst_held.pre", 32'(held0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_held.outs", 32'({hv0, held0, pk0, pl0, cn0}), 0);
        chk("rst_held.idx", 32'({hi0, src0, dst0}), 0);
        clr();
        run(8);
        chk("rst_held.no_cancel", 32'(n_cn[0]), 0);
        clr();
        btn(1, 0, 10, 12);
        chk("rst_held.repick", 32'(n_pk[0]), 1);
        chk("rst_held.src", 32'(src0), 17);

        // Randomised traffic, model-checked every cycle
        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 5))
                0: set_xy($urandom_range(0, 1100), $urandom_range(0, 900));
                1, 2: set_xy(X0 + $urandom_range(0, FILES * SQ - 1), Y0 + $urandom_range(0, RANKS * SQ - 1));
                default: ;
            endcase
            lmb = 1'($urandom_range(0, 1));
            rmb = ($urandom_range(0, 7) == 0);
            pa  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 9)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
